// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit, one bit per cycle; optional macro MDU_EARLY_OUT_EN enables early-out for trivial cases
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] data_one,
  input  logic [XLEN-1:0] data_two,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] md_result,
  output logic            zero
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic neg1_q, neg1_d, neg2_q, neg2_d;
  logic [XLEN-1:0] b_q, b_d, res_q, res_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept, s1, s2, neg1, neg2, ge;
  logic [XLEN-1:0] mag1, mag2, quo, rem, fix_res;
  logic [XLEN:0] mul_sum, div_t, div_diff;
  logic [2*XLEN-1:0] prod_s, mul_next, div_next;
  assign accept    = in_valid && in_ready;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign md_result = res_q;
  assign zero      = out_valid && res_q == '0;
  assign s1   = md_op inside {3'b001, 3'b010, 3'b100, 3'b110};
  assign s2   = md_op inside {3'b001, 3'b100, 3'b110};
  assign neg1 = s1 & data_one[XLEN-1];
  assign neg2 = s2 & data_two[XLEN-1];
  assign mag1 = neg1 ? -data_one : data_one;
  assign mag2 = neg2 ? -data_two : data_two;
  // b_q holds the fixed operand (multiplicand or divisor); acc_q holds product or {remainder, quotient}
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign div_t    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_t - {1'b0, b_q};
  assign ge       = ~div_diff[XLEN];
  assign div_next = {ge ? div_diff[XLEN-1:0] : div_t[XLEN-1:0], acc_q[XLEN-2:0], ge};
  assign prod_s   = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
  assign quo      = acc_q[XLEN-1:0];
  assign rem      = acc_q[2*XLEN-1:XLEN];
  assign fix_res  = ~op_q[2] ? (op_q[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]) :
                    op_q[1]  ? (neg1_q ? -rem : rem) :
                    b_q == '0 ? '1 : ((neg1_q ^ neg2_q) ? -quo : quo);
`ifdef MDU_EARLY_OUT_EN
  logic ovf;
  assign ovf = md_op[2] & ~md_op[0] & (data_one == {1'b1, {(XLEN-1){1'b0}}}) & (data_two == '1);
`endif
  // next-state and datapath update for the sequencer
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg1_d  = neg1_q;
    neg2_d  = neg2_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d    = md_op;
        neg1_d  = neg1;
        neg2_d  = neg2;
        b_d     = md_op[2] ? mag2 : mag1;
        acc_d   = {{XLEN{1'b0}}, md_op[2] ? mag1 : mag2};
        cnt_d   = '0;
        state_d = CALC;
`ifdef MDU_EARLY_OUT_EN
        if (data_two == '0 || ovf) begin
          state_d = DONE;
          res_d   = ~md_op[2] ? '0 : md_op[1] ? (ovf ? '0 : data_one) : (ovf ? data_one : '1);
        end
`endif
      end
      CALC: begin
        acc_d   = op_q[2] ? div_next : mul_next;
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_q == CW'(XLEN-1) ? FIX : CALC;
      end
      FIX: begin
        res_d   = fix_res;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg1_q  <= neg1_d;
      neg2_q  <= neg2_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit at XLEN=32
module tb_mul_div_unit;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0] md_op = '0;
  logic [31:0] data_one = '0, data_two = '0;
  logic in_ready, out_valid, zero;
  logic [31:0] md_result;
  int errors = 0, checks = 0;
`ifdef MDU_EARLY_OUT_EN
  localparam int EO = 1;
`else
  localparam int EO = 34;
`endif
  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .md_op(md_op),
    .data_one(data_one), .data_two(data_two), .out_valid(out_valid), .out_ready(out_ready),
    .md_result(md_result), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int hold);
    int n;
    @(negedge clk);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    md_op     = op;
    data_one  = a;
    data_two  = b;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_one = 32'h5A5A_5A5A;
    data_two = 32'h3;
    md_op    = 3'b000;
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_result"}, md_result, exp);
    chk({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      md_op    = 3'b101;
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_result"}, md_result, exp);
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
  endtask
  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", md_result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    do_op("mul_zero", 3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0, 34, 0);
    do_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
    do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
    do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    do_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34, 0);
    do_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34, 0);
    do_op("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, EO, 0);
    do_op("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, EO, 0);
    do_op("rem_neg_by0", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, EO, 0);
    do_op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, EO, 0);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EO, 0);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, EO, 0);
    do_op("hold", 3'b101, 32'd1000, 32'd10, 32'd100, 34, 10);
    @(posedge clk);
    #1;
    chk("hold_not_queued", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b1;
    md_op    = 3'b101;
    data_one = 32'd100;
    data_two = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("mid_calc_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_result", md_result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op("after_rst", 3'b101, 32'd9, 32'd3, 32'd3, 34, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, even.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state when asserted.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 md_op  input  3  operation select, RV32M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 data_one  input  XLEN  rs1 operand (multiplicand / dividend).
REQ-008 data_two  input  XLEN  rs2 operand (multiplier / divisor).
REQ-009 out_valid  output  1  md_result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 md_result  output  XLEN  result.
REQ-012 zero  output  1  high when md_result == 0, qualified by out_valid (low otherwise).

Function
REQ-013 Request accepted on a rising edge where in_valid && in_ready; operands and md_op captured; later changes on inputs ignored until next acceptance.
REQ-014 States: IDLE -> CALC on accept; CALC -> FIX after exactly XLEN iterations; FIX -> DONE after one cycle; DONE -> IDLE when out_ready sampled high.
REQ-015 CALC: one bit per cycle; multiply = shift-add on operand magnitudes into a 2*XLEN product; divide = restoring shift-subtract on magnitudes.
REQ-016 FIX: apply sign correction; signedness per op: MULH both signed, MULHSU rs1 signed/rs2 unsigned, MULHU/DIVU/REMU unsigned, MUL low half sign-independent, DIV/REM signed.
REQ-017 Results: MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits; DIV/DIVU quotient truncated toward zero; REM/REMU remainder with sign of dividend.
REQ-018 Latency: out_valid rises XLEN+2 cycles after the accepting edge (early-out cases excepted, see REQ-025).
REQ-019 out_valid and md_result held stable in DONE until out_ready sampled high; out_valid may already be high when out_ready rises, transfer completes on that edge.
REQ-020 Back-to-back: in_ready asserts the cycle after the DONE handshake; no accept in the same cycle as result handoff.
REQ-021 Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend; no exception signal.
REQ-022 Signed overflow (dividend = -2^(XLEN-1), divisor = -1): DIV = dividend; REM = 0.
REQ-023 in_valid while busy: ignored, not queued; in_ready low.

Reset
REQ-024 Asserting reset at any time, including mid-CALC or in DONE, immediately forces IDLE, in_ready=1, out_valid=0, md_result=0, zero=0, internal accumulators cleared; the in-flight operation is discarded.

Configuration
REQ-025 Macro MDU_EARLY_OUT_EN: when defined, divide-by-zero, signed-overflow, and any operation with data_two == 0 (multiply yields 0) skip CALC/FIX, going IDLE -> DONE; out_valid rises 1 cycle after accept; results identical to REQ-017/021/022.
REQ-026 Without MDU_EARLY_OUT_EN: all operations take the full XLEN+2 latency; no early-out logic instantiated.

Verification (XLEN=32)
REQ-027 MUL 7 x -3, out_ready=1 -> md_result=0xFFFFFFEB, out_valid at cycle 34 after accept, zero=0.
REQ-028 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-029 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-030 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0, zero=1; with MDU_EARLY_OUT_EN latency 1, without 34.
REQ-031 out_ready held low 10 cycles after out_valid -> result and out_valid stable, in_ready=0, new in_valid ignored; release -> in_ready=1 next cycle.
REQ-032 reset pulsed mid-CALC (cycle 15) -> out_valid=0, in_ready=1 immediately; next request DIVU 9/3 -> 3 with full nominal latency.
